tape_rx: RTL and testbench
==========================

# tape_rx

Cassette input decoder for the ZX81-style pulse-burst tape format. It is the receive-side counterpart of the tape player, sitting between the tape input pin (or a looped-back tape_out) and the loader logic. It measures high and low phases on a 500 kHz clock enable, classifies each pulse burst as a 0 or 1 bit, assembles bytes MSB first and flags framing errors. It also marks block start and block end.

## Interface
- HIGH_MIN, 40: minimum legal high-phase length, ce ticks (nominal 75)
- HIGH_MAX, 110: maximum legal high-phase length, ce ticks
- GAP_TICKS, 300: low length that terminates a bit burst (nominal gap 725 ticks, inter-pulse low 75)
- TIMEOUT_TICKS, 5000: low length that ends a block (10 ms)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ce_500k  in  1  500 kHz clock enable; all timing counts only on ce ticks
- tape_in  in  1  raw tape level, asynchronous to clk
- data  out  8  last completed byte; holds until the next byte
- data_valid  out  1  one-clk strobe, data is new
- first_byte  out  1  qualifies data_valid: byte is the first since block start (filename byte)
- bit_err  out  1  one-clk strobe, burst rejected
- block_end  out  1  one-clk strobe, TIMEOUT_TICKS of low seen after at least one pulse
- busy  out  1  high from first accepted rising edge until block_end or reset

## Operation
- tape_in passes through a 2-FF synchronizer clocked on ce ticks. Edges are detected on the synchronized level only.
- State IDLE: waits for a synchronized rising edge, then enters HIGH. hi_cnt=0, pulse_cnt=1, busy=1, pulse_bad=0.
- State HIGH: hi_cnt increments per tick, saturating at 255.
  - On a falling edge: if hi_cnt < HIGH_MIN or > HIGH_MAX, set pulse_bad. Go to LOW with lo_cnt=0.
- State LOW: lo_cnt (13 bit) increments per tick, saturating at 8191.
  - Rising edge with lo_cnt < GAP_TICKS: pulse_cnt++ (5 bit, saturating at 31), hi_cnt=0, go to HIGH.
  - lo_cnt reaching GAP_TICKS: decide the bit once.
    - pulse_cnt 3..5 gives 0.
    - pulse_cnt 7..11 gives 1.
    - Any other count, or pulse_bad, gives an error.
  - A rising edge after the decision starts a new burst: pulse_cnt=1, pulse_bad=0, go to HIGH.
  - lo_cnt reaching TIMEOUT_TICKS: block_end strobe, busy=0, bit_cnt=0, first flag re-armed, go to IDLE.
- A high phase still running at hi_cnt=255 counts as an error at the next gap decision. There is no other timeout while the level stays high.
- Byte assembly:
  - Shift register sr takes the decided bit at the LSB, shifting left, so the first bit received ends up as bit 7.
  - bit_cnt (3 bit) counts bits. On the 8th bit, data is written with the full byte, data_valid pulses, and first_byte equals the first flag, which then clears.
- Error: bit_err pulses and the bit is discarded. bit_cnt is cleared so the partial byte is dropped. busy stays 1 and the first flag is unchanged.
- Reset (any time, including mid-byte): state IDLE, all counters 0, sr=0, data=8'h00, data_valid=0, first_byte=0, bit_err=0, block_end=0, busy=0, first flag armed.

## Timing
- All state and counter updates occur on clk edges with ce_500k=1.
- The strobes data_valid, bit_err and block_end are set on the deciding ce edge and cleared on the next clk edge, so each lasts exactly one clk cycle regardless of the ce rate.
- Input latency: 2 ce ticks through the synchronizer.
- Bit decision latency: GAP_TICKS ticks after the last synchronized falling edge of the burst.
- data_valid for a byte asserts GAP_TICKS+2 ticks after the last raw falling edge of its 8th burst.
- data and first_byte change only on the same edge as data_valid.
- Simultaneous events:
  - A rising edge on the same tick lo_cnt reaches GAP_TICKS: the decision is taken first, then the new burst starts on that tick.
  - The decision at GAP_TICKS and block_end at TIMEOUT_TICKS never coincide, because GAP_TICKS < TIMEOUT_TICKS is required.
- The 75-tick high and 75-tick low phases of a nominal pulse are well within limits. A nominal 725-tick gap yields the decision at tick 300 of the gap.

## Test plan
- Nominal byte 8'hBF: bursts of 9,4,9,9,9,9,9,9 pulses, each pulse 75 hi / 75 lo, with 725-tick gaps. Required: one data_valid, data=8'hBF, first_byte=1, no bit_err.
- Two bytes 8'hBF then 8'h55, followed by 12 ms of low. Required:
  - data_valid twice; second byte first_byte=0, data=8'h55.
  - block_end once, 5000 ticks after the last falling edge; busy drops on the same edge.
  - A following 8'h00 byte reports first_byte=1.
- Burst of 6 pulses as the 3rd bit, then 8 valid bits encoding 8'hA5. Required: bit_err once, at the gap after the bad burst; next data_valid carries data=8'hA5.
- High phase of 20 ticks inside a 4-pulse burst. Required: bit_err, no data_valid for that byte position. A 200-tick high phase gives the same result.
- reset_n asserted asynchronously after 5 bits of a byte, then a full 8'h3C byte. Required:
  - All outputs 0 immediately on assertion.
  - After release, data=8'h3C with first_byte=1; no stale bits merged.
- Inter-pulse low of 299 ticks, then another pulse. Required: counted in the same burst. With a 300-tick low, the bit is decided and the pulse starts a new burst.

Source files
------------

// File: rtl/tape_rx.sv
// Cassette pulse-burst decoder: measures high/low phases on a 500 kHz enable,
// classifies bursts as 0/1 bits, assembles bytes MSB first and marks block ends.
module tape_rx #(
  parameter int HIGH_MIN      = 40,
  parameter int HIGH_MAX      = 110,
  parameter int GAP_TICKS     = 300,
  parameter int TIMEOUT_TICKS = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_500k,
  input  logic       tape_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       first_byte,
  output logic       bit_err,
  output logic       block_end,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam logic [7:0]  HMIN_L = 8'(HIGH_MIN);
  localparam logic [7:0]  HMAX_L = 8'(HIGH_MAX);
  localparam logic [12:0] GAP_L  = 13'(GAP_TICKS);
  localparam logic [12:0] TO_L   = 13'(TIMEOUT_TICKS);

  // Burst classification: {valid, bit value}; 3..5 pulses is a 0, 7..11 is a 1.
  function automatic logic [1:0] classify_burst(input logic [4:0] pulses, input logic bad);
    logic is_zero;
    logic is_one;
    is_zero = (pulses >= 5'd3) && (pulses <= 5'd5);
    is_one  = (pulses >= 5'd7) && (pulses <= 5'd11);
    classify_burst = {(~bad) & (is_zero | is_one), is_one};
  endfunction

  state_e      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [7:0]  hi_cnt_q, hi_cnt_d;
  logic [12:0] lo_cnt_q, lo_cnt_d;
  logic [4:0]  pulse_cnt_q, pulse_cnt_d;
  logic        pulse_bad_q, pulse_bad_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        first_q, first_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        first_byte_q, first_byte_d;
  logic        bit_err_q, bit_err_d;
  logic        block_end_q, block_end_d;
  logic        busy_q, busy_d;

  logic        rise_s;
  logic        fall_s;
  logic [7:0]  hi_n_s;
  logic [12:0] lo_n_s;
  logic [4:0]  pulse_inc_s;
  logic [1:0]  decide_s;

  // Edges are taken as the synchronized level changes, so the FSM reacts on the
  // same tick the second stage flop updates.
  always_comb begin
    rise_s      = sync1_q & ~sync2_q;
    fall_s      = ~sync1_q & sync2_q;
    hi_n_s      = (hi_cnt_q == 8'd255) ? 8'd255 : hi_cnt_q + 8'd1;
    lo_n_s      = (lo_cnt_q == 13'd8191) ? 13'd8191 : lo_cnt_q + 13'd1;
    pulse_inc_s = (pulse_cnt_q == 5'd31) ? 5'd31 : pulse_cnt_q + 5'd1;
    decide_s    = classify_burst(pulse_cnt_q, pulse_bad_q);
  end

  // Next-state logic for synchronizer, phase FSM, byte assembly and strobes.
  always_comb begin
    state_d      = state_q;
    sync1_d      = sync1_q;
    sync2_d      = sync2_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    pulse_bad_d  = pulse_bad_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    first_d      = first_q;
    data_d       = data_q;
    first_byte_d = first_byte_q;
    busy_d       = busy_q;
    data_valid_d = 1'b0;
    bit_err_d    = 1'b0;
    block_end_d  = 1'b0;

    if (ce_500k) begin
      sync1_d = tape_in;
      sync2_d = sync1_q;
      case (state_q)
        S_IDLE: begin
          if (rise_s) begin
            state_d     = S_HIGH;
            hi_cnt_d    = 8'd0;
            pulse_cnt_d = 5'd1;
            pulse_bad_d = 1'b0;
            busy_d      = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HIGH: begin
          hi_cnt_d = hi_n_s;
          if (fall_s) begin
            if ((hi_n_s < HMIN_L) || (hi_n_s > HMAX_L)) begin
              pulse_bad_d = 1'b1;
            end else begin
              pulse_bad_d = pulse_bad_q;
            end
            state_d  = S_LOW;
            lo_cnt_d = 13'd0;
          end else begin
            state_d = S_HIGH;
          end
        end
        S_LOW: begin
          lo_cnt_d = lo_n_s;
          if (lo_n_s == TO_L) begin
            block_end_d = 1'b1;
            busy_d      = 1'b0;
            bit_cnt_d   = 3'd0;
            first_d     = 1'b1;
            lo_cnt_d    = 13'd0;
            state_d     = S_IDLE;
          end else begin
            // The decision is taken before a coincident rising edge restarts the burst.
            if (lo_n_s == GAP_L) begin
              if (!decide_s[1]) begin
                bit_err_d = 1'b1;
                bit_cnt_d = 3'd0;
              end else if (bit_cnt_q == 3'd7) begin
                sr_d         = {sr_q[6:0], decide_s[0]};
                data_d       = {sr_q[6:0], decide_s[0]};
                data_valid_d = 1'b1;
                first_byte_d = first_q;
                first_d      = 1'b0;
                bit_cnt_d    = 3'd0;
              end else begin
                sr_d      = {sr_q[6:0], decide_s[0]};
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q;
            end
            if (rise_s) begin
              state_d  = S_HIGH;
              hi_cnt_d = 8'd0;
              if (lo_n_s >= GAP_L) begin
                pulse_cnt_d = 5'd1;
                pulse_bad_d = 1'b0;
              end else begin
                pulse_cnt_d = pulse_inc_s;
              end
            end else begin
              state_d = S_LOW;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hi_cnt_q     <= 8'd0;
      lo_cnt_q     <= 13'd0;
      pulse_cnt_q  <= 5'd0;
      pulse_bad_q  <= 1'b0;
      sr_q         <= 8'd0;
      bit_cnt_q    <= 3'd0;
      first_q      <= 1'b1;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      first_byte_q <= 1'b0;
      bit_err_q    <= 1'b0;
      block_end_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      pulse_bad_q  <= pulse_bad_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      first_q      <= first_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      first_byte_q <= first_byte_d;
      bit_err_q    <= bit_err_d;
      block_end_q  <= block_end_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign first_byte = first_byte_q;
  assign bit_err    = bit_err_q;
  assign block_end  = block_end_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tape_rx.sv
// Directed bench for tape_rx: drives pulse bursts tick by tick and checks
// bytes, errors, block end, latencies and reset behaviour.
module tb_tape_rx;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_500k = 1'b1;
  logic       tape_in = 1'b0;
  logic [7:0] data;
  logic       data_valid, first_byte, bit_err, block_end, busy;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int ce_div = 1;
  int ce_ph = 0;
  int hi_t, lo_t, gap_t, one_n, zero_n;

  int dv_cnt = 0, err_cnt = 0, be_cnt = 0;
  int dv_tick = 0, be_tick = 0;
  logic [7:0] dv_data = 8'h00;
  logic dv_first = 1'b0, be_busy = 1'b0;
  int err_ticks[$];

  tape_rx dut (
    .clk(clk), .reset_n(reset_n), .ce_500k(ce_500k), .tape_in(tape_in),
    .data(data), .data_valid(data_valid), .first_byte(first_byte),
    .bit_err(bit_err), .block_end(block_end), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ce_ph + 1 >= ce_div) begin
      ce_ph   <= 0;
      ce_500k <= 1'b1;
    end else begin
      ce_ph   <= ce_ph + 1;
      ce_500k <= 1'b0;
    end
  end

  always @(posedge clk) if (ce_500k) tick_cnt <= tick_cnt + 1;

  // Strobe monitor: counts every clk cycle a strobe is high.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt   <= dv_cnt + 1;
      dv_data  <= data;
      dv_first <= first_byte;
      dv_tick  <= tick_cnt;
    end
    if (bit_err) begin
      err_cnt <= err_cnt + 1;
      err_ticks.push_back(tick_cnt);
    end
    if (block_end) begin
      be_cnt  <= be_cnt + 1;
      be_tick <= tick_cnt;
      be_busy <= busy;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (ce_500k !== 1'b1) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pulses(input int n, input int bad_idx, input int bad_hi,
                             input int gap, output int fall);
    for (int i = 0; i < n; i++) begin
      tape_in = 1'b1;
      tick((i == bad_idx) ? bad_hi : hi_t);
      tape_in = 1'b0;
      fall = tick_cnt;
      tick((i < n - 1) ? lo_t : gap);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int fall);
    for (int i = 7; i >= 0; i--) send_pulses(b[i] ? one_n : zero_n, -1, 0, gap_t, fall);
  endtask

  task automatic set_fast();
    hi_t = 45; lo_t = 45; gap_t = 310; one_n = 7; zero_n = 3;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    tape_in = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++;
    if ({data_valid, first_byte, bit_err, block_end, busy} !== 5'b00000) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {data_valid, first_byte, bit_err, block_end, busy});
    end
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    tick(20);
    checks++;
    if ({data_valid, bit_err, block_end, busy} !== 4'b0000) begin
      failures++; $display("FAIL idle_flags got=%b exp=0000", {data_valid, bit_err, block_end, busy});
    end
  endtask

  task automatic test_nominal_byte();
    int d0, e0, f;
    hi_t = 75; lo_t = 75; gap_t = 725; one_n = 9; zero_n = 4;
    d0 = dv_cnt; e0 = err_cnt;
    send_byte(8'hBF, f);
    checks++;
    if (dv_cnt - d0 != 1) begin failures++; $display("FAIL nom_dv_count got=%0d exp=1", dv_cnt - d0); end
    checks++;
    if (dv_data !== 8'hBF) begin failures++; $display("FAIL nom_data got=%h exp=bf", dv_data); end
    checks++;
    if (dv_first !== 1'b1) begin failures++; $display("FAIL nom_first got=%b exp=1", dv_first); end
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL nom_err got=%0d exp=0", err_cnt - e0); end
    checks++;
    if (dv_tick - f != 302) begin failures++; $display("FAIL nom_latency got=%0d exp=302", dv_tick - f); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL nom_busy got=%b exp=1", busy); end
  endtask

  task automatic test_two_bytes_block_end();
    int d0, b0, f;
    set_fast();
    d0 = dv_cnt; b0 = be_cnt;
    send_byte(8'h55, f);
    checks++;
    if (dv_cnt - d0 != 1) begin failures++; $display("FAIL b2_dv_count got=%0d exp=1", dv_cnt - d0); end
    checks++;
    if (dv_data !== 8'h55 || dv_first !== 1'b0) begin
      failures++; $display("FAIL b2_data got=%h/%b exp=55/0", dv_data, dv_first);
    end
    tick(6000);
    checks++;
    if (be_cnt - b0 != 1) begin failures++; $display("FAIL blk_end_count got=%0d exp=1", be_cnt - b0); end
    checks++;
    if (be_tick - f != 5002) begin failures++; $display("FAIL blk_end_latency got=%0d exp=5002", be_tick - f); end
    checks++;
    if (be_busy !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL blk_busy got=%b/%b exp=0/0", be_busy, busy);
    end
    d0 = dv_cnt;
    send_byte(8'h00, f);
    checks++;
    if (dv_cnt - d0 != 1 || dv_data !== 8'h00 || dv_first !== 1'b1) begin
      failures++; $display("FAIL new_block_byte got=%0d/%h/%b exp=1/00/1", dv_cnt - d0, dv_data, dv_first);
    end
  endtask

  task automatic test_bad_high();
    int d0, e0, f;
    do_reset();
    set_fast();
    d0 = dv_cnt; e0 = err_cnt;
    for (int i = 0; i < 7; i++) send_pulses(zero_n, -1, 0, gap_t, f);
    send_pulses(4, 1, 20, gap_t, f);
    checks++;
    if (err_cnt - e0 != 1 || dv_cnt != d0) begin
      failures++; $display("FAIL short_high got err=%0d dv=%0d exp err=1 dv=0", err_cnt - e0, dv_cnt - d0);
    end
    send_pulses(4, 2, 200, gap_t, f);
    checks++;
    if (err_cnt - e0 != 2 || dv_cnt != d0) begin
      failures++; $display("FAIL long_high got err=%0d dv=%0d exp err=2 dv=0", err_cnt - e0, dv_cnt - d0);
    end
    checks++;
    if (err_ticks[err_ticks.size() - 1] - f != 302) begin
      failures++; $display("FAIL long_high_latency got=%0d exp=302", err_ticks[err_ticks.size() - 1] - f);
    end
  endtask

  task automatic test_bad_count();
    int d0, e0, f, fb;
    do_reset();
    set_fast();
    d0 = dv_cnt; e0 = err_cnt;
    send_pulses(one_n, -1, 0, gap_t, f);
    send_pulses(zero_n, -1, 0, gap_t, f);
    send_pulses(6, -1, 0, gap_t, fb);
    checks++;
    if (err_cnt - e0 != 1 || err_ticks[err_ticks.size() - 1] - fb != 302) begin
      failures++; $display("FAIL six_pulse_err got=%0d exp=1 at +302", err_cnt - e0);
    end
    send_byte(8'hA5, f);
    checks++;
    if (dv_cnt - d0 != 1 || dv_data !== 8'hA5) begin
      failures++; $display("FAIL after_err_byte got=%0d/%h exp=1/a5", dv_cnt - d0, dv_data);
    end
    checks++;
    if (dv_first !== 1'b1 || err_cnt - e0 != 1) begin
      failures++; $display("FAIL after_err_first got=%b/%0d exp=1/1", dv_first, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_byte();
    int d0, e0, f;
    set_fast();
    for (int i = 0; i < 5; i++) send_pulses(one_n, -1, 0, gap_t, f);
    checks++;
    if (busy !== 1'b1 || data !== 8'hA5 || first_byte !== 1'b1) begin
      failures++; $display("FAIL pre_reset got=%b/%h/%b exp=1/a5/1", busy, data, first_byte);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({data, data_valid, first_byte, bit_err, block_end, busy} !== 13'd0) begin
      failures++; $display("FAIL async_reset got=%h %b exp=00 00000", data, {data_valid, first_byte, bit_err, block_end, busy});
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick(3);
    d0 = dv_cnt; e0 = err_cnt;
    send_byte(8'h3C, f);
    checks++;
    if (dv_cnt - d0 != 1 || dv_data !== 8'h3C || dv_first !== 1'b1 || err_cnt != e0) begin
      failures++; $display("FAIL post_reset_byte got=%0d/%h/%b exp=1/3c/1", dv_cnt - d0, dv_data, dv_first);
    end
  endtask

  task automatic test_gap_boundary();
    int d0, e0, f;
    do_reset();
    set_fast();
    ce_div = 3;
    d0 = dv_cnt; e0 = err_cnt;
    send_pulses(2, -1, 0, 299, f);
    send_pulses(1, -1, 0, gap_t, f);
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL low_299 got err=%0d exp=0", err_cnt - e0); end
    e0 = err_cnt;
    send_pulses(2, -1, 0, 300, f);
    send_pulses(1, -1, 0, gap_t, f);
    checks++;
    if (err_cnt - e0 != 2) begin failures++; $display("FAIL low_300 got err cycles=%0d exp=2", err_cnt - e0); end
    checks++;
    if (err_ticks.size() < 2 || err_ticks[err_ticks.size() - 2] - (f - 345) != 302) begin
      failures++; $display("FAIL low_300_decision_tick got=%0d exp=302", (err_ticks.size() < 2) ? -1 : err_ticks[err_ticks.size() - 2] - (f - 345));
    end
    checks++;
    if (dv_cnt != d0) begin failures++; $display("FAIL gap_dv got=%0d exp=0", dv_cnt - d0); end
    ce_div = 1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_nominal_byte();
    test_two_bytes_block_end();
    test_bad_high();
    test_bad_count();
    test_reset_mid_byte();
    test_gap_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
